// File: rtl/array_15_arb.sv
// Round-robin arbiter/sequencer sharing one single-port 512x84 SRAM macro between two requesters.
// Optional ARRAY_INIT_EN: zero-fill sweep of the whole array after reset (busy high while sweeping).
module array_15_arb #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 84,
  parameter int unsigned LANES  = 4
) (
  input  logic              clock,
  input  logic              reset_n,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [LANES-1:0]  req0_mask,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [LANES-1:0]  req1_mask,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,

  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,

  output logic              busy
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

`ifdef ARRAY_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              rr_ptr_q;
  logic              rd_pend_q;
  logic              rd_id_q;
  logic              gnt0, gnt1;
  logic              fire;
  logic              fire_write;

  // State, round-robin pointer and read-return tracking.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_STATE;
      init_cnt_q <= '0;
      rr_ptr_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      if (fire) begin
        rr_ptr_q <= gnt0;
      end
      rd_pend_q <= fire && !fire_write;
      if (fire && !fire_write) begin
        rd_id_q <= gnt1;
      end
    end
  end

  // Next state, grant and macro drive; nothing reaches the macro while reset is held.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    fire_write = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    case (state_q)
      ST_INIT: begin
        if (reset_n) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = init_cnt_q;
          sram_wmask = '1;
          init_cnt_d = init_cnt_q + ADDR_W'(1);
          if (init_cnt_q == '1) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (reset_n) begin
          gnt1 = req1_valid && (!req0_valid || rr_ptr_q);
          gnt0 = req0_valid && !gnt1;
          if (gnt1) begin
            sram_en    = 1'b1;
            sram_wmode = req1_write;
            sram_addr  = req1_addr;
            sram_wmask = req1_mask;
            sram_wdata = req1_wdata;
            fire_write = req1_write;
          end else if (gnt0) begin
            sram_en    = 1'b1;
            sram_wmode = req0_write;
            sram_addr  = req0_addr;
            sram_wmask = req0_mask;
            sram_wdata = req0_wdata;
            fire_write = req0_write;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  assign fire       = gnt0 | gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Read data is steered to whoever issued the read one cycle earlier.
  assign resp0_valid = rd_pend_q && !rd_id_q;
  assign resp1_valid = rd_pend_q && rd_id_q;
  assign resp0_data  = resp0_valid ? sram_rdata : '0;
  assign resp1_data  = resp1_valid ? sram_rdata : '0;

`ifdef ARRAY_INIT_EN
  assign busy = (state_q == ST_INIT);
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_array_15_arb.sv
// Directed bench for array_15_arb with a behavioural 512x84 lane-masked SRAM model.
module tb_array_15_arb;

  localparam logic [83:0] ONES = {84{1'b1}};
  localparam logic [83:0] A    = {21'h1FFFFF, 21'h0, 21'h1FFFFF, 21'h0};
  localparam logic [83:0] B    = 84'h123;

  logic        clock, reset_n;
  logic        req0_valid, req0_ready, req0_write;
  logic [8:0]  req0_addr;
  logic [3:0]  req0_mask;
  logic [83:0] req0_wdata;
  logic        resp0_valid;
  logic [83:0] resp0_data;
  logic        req1_valid, req1_ready, req1_write;
  logic [8:0]  req1_addr;
  logic [3:0]  req1_mask;
  logic [83:0] req1_wdata;
  logic        resp1_valid;
  logic [83:0] resp1_data;
  logic        sram_en, sram_wmode;
  logic [8:0]  sram_addr;
  logic [3:0]  sram_wmask;
  logic [83:0] sram_wdata, sram_rdata;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  array_15_arb dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_mask(req0_mask), .req0_wdata(req0_wdata),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_mask(req1_mask), .req1_wdata(req1_wdata),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: lane-masked write, registered read data.
  logic [83:0] mem [512];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        logic [83:0] w;
        w = mem[sram_addr];
        for (int l = 0; l < 4; l++)
          if (sram_wmask[l]) w[l*21 +: 21] = sram_wdata[l*21 +: 21];
        mem[sram_addr] <= w;
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic v0, w0; logic [8:0] a0; logic [3:0] m0; logic [83:0] d0;
    logic v1, w1; logic [8:0] a1; logic [3:0] m1; logic [83:0] d1;
    logic r0, r1, en, wm; logic [8:0] ea;
    logic rv0, rv1; logic [83:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic v0, w0, input logic [8:0] a0, input logic [3:0] m0, input logic [83:0] d0,
    input logic v1, w1, input logic [8:0] a1, input logic [3:0] m1, input logic [83:0] d1,
    input logic r0, r1, en, wm, input logic [8:0] ea,
    input logic rv0, rv1, input logic [83:0] rd);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.m0 = m0; v.d0 = d0;
    v.v1 = v1; v.w1 = w1; v.a1 = a1; v.m1 = m1; v.d1 = d1;
    v.r0 = r0; v.r1 = r1; v.en = en; v.wm = wm; v.ea = ea;
    v.rv0 = rv0; v.rv1 = rv1; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Bounded wait for any init sweep to finish.
  task automatic wait_init();
    int n = 0;
    while (busy === 1'b1 && n < 600) begin
      @(negedge clock);
      n++;
    end
    chk("init_done", 84'(busy), 84'(0));
  endtask

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h1FF; req0_mask = '0; req0_wdata = '0;
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h000; req1_mask = '0; req1_wdata = '0;
    repeat (2) @(negedge clock);
    #2;
    chk("rst_ready0", 84'(req0_ready), 84'(0));
    chk("rst_ready1", 84'(req1_ready), 84'(0));
    chk("rst_sram_en", 84'(sram_en), 84'(0));
    chk("rst_resp_valid", 84'({resp0_valid, resp1_valid}), 84'(0));
    chk("rst_resp0_data", resp0_data, 84'(0));
`ifdef ARRAY_INIT_EN
    chk("rst_busy", 84'(busy), 84'(1));
`else
    chk("rst_busy", 84'(busy), 84'(0));
`endif
    @(negedge clock);
    req1_valid = 1'b0;
`ifndef ARRAY_INIT_EN
    req0_valid = 1'b0;
`endif
    reset_n = 1'b1;

`ifdef ARRAY_INIT_EN
    // Sweep: one zero write per cycle, requester held off throughout.
    for (int i = 0; i < 512; i++) begin
      #2;
      chk($sformatf("init_cyc%0d", i),
          84'({busy, sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata == 84'(0), req0_ready}),
          84'({1'b1, 1'b1, 1'b1, 9'(i), 4'hF, 1'b1, 1'b0}));
      @(negedge clock);
    end
    #2;
    chk("init_end_busy", 84'(busy), 84'(0));
    chk("init_end_grant", 84'({req0_ready, sram_en, sram_wmode, sram_addr}), 84'({3'b110, 9'h1FF}));
    @(negedge clock);
    req0_valid = 1'b0;
    #2;
    chk("init_rd_valid", 84'(resp0_valid), 84'(1));
    chk("init_rd_data", resp0_data, 84'(0));
    @(negedge clock);
`endif

    // Table: masked write/read, zero-mask write, contention, fairness after idle.
    vecs.push_back(mk(1,1,9'h005,4'hF,ONES, 0,0,9'h000,4'h0,84'h0, 1,0,1,1,9'h005, 0,0,84'h0));
    vecs.push_back(mk(1,1,9'h005,4'h5,84'h0, 0,0,9'h000,4'h0,84'h0, 1,0,1,1,9'h005, 0,0,84'h0));
    vecs.push_back(mk(1,0,9'h005,4'h0,84'h0, 0,0,9'h000,4'h0,84'h0, 1,0,1,0,9'h005, 0,0,84'h0));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 0,0,9'h000,4'h0,84'h0, 0,0,0,0,9'h000, 1,0,A));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 1,1,9'h010,4'hF,B,     0,1,1,1,9'h010, 0,0,84'h0));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 1,1,9'h010,4'h0,84'h3FF, 0,1,1,1,9'h010, 0,0,84'h0));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 1,0,9'h010,4'h0,84'h0, 0,1,1,0,9'h010, 0,0,84'h0));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 0,0,9'h000,4'h0,84'h0, 0,0,0,0,9'h000, 0,1,B));
    for (int c = 0; c < 6; c++)
      vecs.push_back(mk(1,0,9'h005,4'h0,84'h0, 1,0,9'h010,4'h0,84'h0,
                        (c % 2) == 0, (c % 2) == 1, 1, 0, (c % 2) ? 9'h010 : 9'h005,
                        c > 0 && (c % 2) == 1, c > 0 && (c % 2) == 0, (c % 2) ? A : B));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 0,0,9'h000,4'h0,84'h0, 0,0,0,0,9'h000, 0,1,B));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 1,0,9'h010,4'h0,84'h0, 0,1,1,0,9'h010, 0,0,84'h0));
    vecs.push_back(mk(1,0,9'h005,4'h0,84'h0, 1,0,9'h010,4'h0,84'h0, 1,0,1,0,9'h005, 0,1,B));
    vecs.push_back(mk(0,0,9'h000,4'h0,84'h0, 0,0,9'h000,4'h0,84'h0, 0,0,0,0,9'h000, 1,0,A));

    foreach (vecs[i]) begin
      req0_valid = vecs[i].v0; req0_write = vecs[i].w0; req0_addr = vecs[i].a0;
      req0_mask  = vecs[i].m0; req0_wdata = vecs[i].d0;
      req1_valid = vecs[i].v1; req1_write = vecs[i].w1; req1_addr = vecs[i].a1;
      req1_mask  = vecs[i].m1; req1_wdata = vecs[i].d1;
      #2;
      chk($sformatf("row%0d ready", i), 84'({req0_ready, req1_ready}), 84'({vecs[i].r0, vecs[i].r1}));
      chk($sformatf("row%0d en_wmode", i), 84'({sram_en, sram_wmode}), 84'({vecs[i].en, vecs[i].wm}));
      if (vecs[i].en) chk($sformatf("row%0d addr", i), 84'(sram_addr), 84'(vecs[i].ea));
      chk($sformatf("row%0d resp_valid", i), 84'({resp0_valid, resp1_valid}),
          84'({vecs[i].rv0, vecs[i].rv1}));
      if (vecs[i].rv0) chk($sformatf("row%0d resp0_data", i), resp0_data, vecs[i].rd);
      if (vecs[i].rv1) chk($sformatf("row%0d resp1_data", i), resp1_data, vecs[i].rd);
      @(negedge clock);
    end

    // Reset lands while a req1 read response is pending.
    req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h010;
    #2;
    chk("mid_rd_ready1", 84'(req1_ready), 84'(1));
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("mid_rd_resp1", 84'(resp1_valid), 84'(0));
    chk("mid_rd_sram_en", 84'(sram_en), 84'(0));
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("mid_rd_ready_held", 84'({req0_ready, req1_ready}), 84'(0));
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_n = 1'b1;
    wait_init();
    #2;
    chk("post_rst_idle", 84'({sram_en, resp0_valid, resp1_valid}), 84'(0));
    @(negedge clock);
    #2;
    chk("post_rst_resp1", 84'(resp1_valid), 84'(0));
    @(negedge clock);

    // Pointer left at 1 by a req0 fire must come back as 0 after reset.
    req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 9'h005;
    #2;
    chk("ptr_setup_ready0", 84'(req0_ready), 84'(1));
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    wait_init();
    req0_valid = 1'b1; req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 9'h010;
    #2;
    chk("ptr_rst_grant", 84'({req0_ready, req1_ready}), 84'(2'b10));
    chk("ptr_rst_addr", 84'(sram_addr), 84'(9'h005));
    @(negedge clock);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2;
    chk("ptr_rst_resp", 84'({resp0_valid, resp1_valid}), 84'(2'b10));
    @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/array_15_arb.md
Name: array_15_arb

Overview:
- Two-requester arbiter and sequencer for one single-port 512x84 SRAM macro.
- The macro has 4 write lanes of 21 bits and a 1-cycle registered-address read.
- Shares the macro's single RW port between requester 0 and requester 1 using round-robin arbitration, and returns read data to the issuing requester.
- Sits between the pipeline clients and the array macro.

Parameters:
- ADDR_W, 9, address width; depth = 2^ADDR_W = 512.
- DATA_W, 84, data width.
- LANES, 4, write-mask lanes; lane width = DATA_W/LANES = 21.

Ports:
- clock  in  1  sole clock; rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N=0,1) request present.
- reqN_ready  out  1  request accepted this cycle.
- reqN_write  in  1  1=write, 0=read.
- reqN_addr  in  ADDR_W  word address.
- reqN_mask  in  LANES  lane write enables; ignored for reads.
- reqN_wdata  in  DATA_W  write data.
- respN_valid  out  1  read data valid; one-cycle pulse, no backpressure.
- respN_data  out  DATA_W  read data.
- sram_en  out  1  macro enable.
- sram_wmode  out  1  macro write mode.
- sram_addr  out  ADDR_W  macro address.
- sram_wmask  out  LANES  macro lane mask.
- sram_wdata  out  DATA_W  macro write data.
- sram_rdata  in  DATA_W  macro read data, valid the cycle after a read.
- busy  out  1  initialisation sweep in progress.

Behaviour:
- Reset: reset_n low asynchronously clears the following to 0:
  - rr_ptr
  - rd_pend
  - rd_id
  - respN_valid
  - init counter
  - all registered state
- While reset_n is low:
  - sram_en=0 and reqN_ready=0.
  - respN_data is 0.
- State machine: INIT -> RUN.
  - With ARRAY_INIT_EN: reset enters INIT.
  - Without ARRAY_INIT_EN: reset enters RUN directly.
  - RUN is terminal until the next reset.
- RUN, arbitration (combinational, one grant per cycle):
  - Only req0_valid high: grant 0.
  - Only req1_valid high: grant 1.
  - Both high: grant the requester rr_ptr points to.
  - reqN_ready = grant to N.
  - Fire = valid & ready.
- rr_ptr update: on any fire, rr_ptr <= the other requester. With no fire, rr_ptr holds.
- Macro drive on fire (combinational pass-through, zero added latency):
  - sram_en=1.
  - sram_wmode=reqN_write.
  - sram_addr=reqN_addr.
  - sram_wmask=reqN_mask.
  - sram_wdata=reqN_wdata.
- Macro drive with no fire:
  - sram_en=0 and sram_wmode=0.
  - Other sram outputs may hold don't-care values.
- Writes:
  - Complete at the fire edge; no response is produced.
  - A write with mask 0 is still accepted and issued; it has no effect on memory.
- Read response:
  - On a read fire, rd_pend<=1 and rd_id<=N; otherwise rd_pend<=0.
  - The cycle after the read fire, resp[rd_id]_valid=1 and resp[rd_id]_data=sram_rdata.
  - respN_data is undefined while respN_valid=0.
- Throughput:
  - One access per cycle total.
  - Back-to-back reads from alternating requesters give responses on consecutive cycles.
- Read after write:
  - A read of an address written in the preceding cycle returns the new lane data.
  - Unmasked lanes return the old data.
- Reset mid-operation: an in-flight read response is dropped; respN_valid stays 0 after reset deassertion.
- No request queueing: a requester must hold valid and its payload stable until ready.

Optional Feature:
- Macro: ARRAY_INIT_EN.
- Defined, INIT sweep:
  - After reset, INIT writes zero to every address 0..511 in ascending order, one per cycle.
  - Each sweep write uses sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0.
  - The sweep takes exactly 512 cycles.
- Defined, behaviour during INIT:
  - busy=1 and reqN_ready=0.
  - After the write to address 511, the next cycle is RUN with busy=0.
  - The init counter wraps at 511 without overflow.
- Not defined:
  - busy is tied 0.
  - The block is in RUN from the first cycle after reset; memory contents are left uninitialised.

Test Plan:
- Init (ARRAY_INIT_EN defined):
  - Stimulus: release reset; keep req0_valid=1 throughout.
  - Required: busy=1 for exactly 512 cycles; sram_addr runs 0..511 with wdata=0 and mask=4'hF; req0_ready=0 until busy falls; a read of address 0x1FF afterwards returns 0.
- Masked write/read:
  - Stimulus: req0 writes addr 0x005, data all-ones, mask 4'b1111; then writes addr 0x005, data 0, mask 4'b0101; then req0 reads addr 0x005.
  - Required: resp0_valid one cycle after the read fire; resp0_data = 84'h{lanes3,1 = 1FFFFF, lanes2,0 = 0}.
- Contention:
  - Stimulus: both requesters hold valid reads for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1; resp0_valid and resp1_valid alternate on consecutive cycles; no cycle has both high.
- Fairness after idle:
  - Stimulus: only req1 fires once; then both assert valid.
  - Required: req0 is granted first.
- Reset mid-read:
  - Stimulus: req1 read fires; reset_n asserts low before the next edge.
  - Required: resp1_valid stays 0; after release, rr_ptr=0 and sram_en=0 with no requests.
- Zero-mask write:
  - Stimulus: req1 writes addr 0x010 with mask 0 over known data 0x123; then reads addr 0x010.
  - Required: req1_ready=1 and sram_en=1 on the write; the read returns 0x123.
